// File: rtl/test_capture_buffer.sv
// Triggered, decimated burst capture of the 16-bit audio test port into block RAM,
// read back by the CPU one byte pair at a time. Optional pre-trigger history: TEST_CAPTURE_PRETRIG_EN.
module test_capture_buffer #(
    parameter int ADDR_W = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic        test_dout_valid_i,
    input  logic [15:0] test_data_out_i,
    input  logic [7:0]  cap_control_i,
    input  logic [7:0]  cap_thresh_lsb_i,
    input  logic [7:0]  cap_thresh_msb_i,
    input  logic        rd_en_i,
    output logic [7:0]  rd_lsb_data_o,
    output logic [7:0]  rd_msb_data_o,
    output logic [7:0]  cap_status_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
`ifdef TEST_CAPTURE_PRETRIG_EN
    localparam logic [ADDR_W:0]   HALF_C = (ADDR_W+1)'(DEPTH/2);
    localparam logic [ADDR_W-1:0] HALF_A = ADDR_W'(DEPTH/2);
`endif

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]        decim_cnt_q, decim_cnt_d;
    logic [15:0]       prev_q, prev_d;
    logic              arm_dly_q;
    logic [7:0]        status_q, status_d;
`ifdef TEST_CAPTURE_PRETRIG_EN
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
`endif

    logic [15:0]       mem [0:DEPTH-1];
    logic [15:0]       rd_word_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] mem_raddr;

    logic        arm_rise;
    logic        trig_mode;
    logic        abort;
    logic        rd_addr_rst;
    logic [3:0]  decim;
    logic        accept;
    logic [15:0] thresh;
    logic        trig_hit;
    logic        decim_hit;
    logic        rd_end_d;

    assign arm_rise    = cap_control_i[0] & ~arm_dly_q;
    assign trig_mode   = cap_control_i[1];
    assign abort       = cap_control_i[2];
    assign rd_addr_rst = cap_control_i[3];
    assign decim       = cap_control_i[7:4];
    assign accept      = test_dout_valid_i & run_i;
    assign thresh      = {cap_thresh_msb_i, cap_thresh_lsb_i};

    // Threshold trigger fires only on a rising crossing, not while the signal sits above it.
    assign trig_hit = ~trig_mode
                    | (($signed(test_data_out_i) >= $signed(thresh))
                       & ($signed(prev_q) < $signed(thresh)));

    // >= rather than == so a decimation ratio lowered mid-burst cannot stall the counter.
    assign decim_hit = (decim_cnt_q >= decim);

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        decim_cnt_d = decim_cnt_q;
        prev_d      = prev_q;
        mem_we      = 1'b0;
        mem_waddr   = '0;
`ifdef TEST_CAPTURE_PRETRIG_EN
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        rd_base_d   = rd_base_q;
`endif
        if (abort) begin
            state_d  = S_IDLE;
            wr_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_rise) begin
                        state_d     = S_ARMED;
                        wr_cnt_d    = '0;
                        rd_ptr_d    = '0;
                        decim_cnt_d = '0;
                        prev_d      = '0;
`ifdef TEST_CAPTURE_PRETRIG_EN
                        wr_ptr_d    = '0;
                        fill_d      = '0;
`endif
                    end else if (state_q == S_DONE) begin
                        if (rd_addr_rst)
                            rd_ptr_d = '0;
                        else if (rd_en_i && ({1'b0, rd_ptr_q} < (wr_cnt_q - ONE_C)))
                            rd_ptr_d = rd_ptr_q + ONE_A;
                    end
                end
                S_ARMED: begin
                    if (accept) begin
                        prev_d = test_data_out_i;
`ifdef TEST_CAPTURE_PRETRIG_EN
                        if (trig_hit && (fill_q == HALF_A)) begin
                            mem_we      = 1'b1;
                            mem_waddr   = wr_ptr_q;
                            wr_ptr_d    = wr_ptr_q + ONE_A;
                            rd_base_d   = wr_ptr_q - HALF_A;
                            wr_cnt_d    = HALF_C + ONE_C;
                            decim_cnt_d = '0;
                            state_d     = ((HALF_C + ONE_C) == DEPTH_C) ? S_DONE : S_CAPTURE;
                        end else if (decim_hit) begin
                            mem_we      = 1'b1;
                            mem_waddr   = wr_ptr_q;
                            wr_ptr_d    = wr_ptr_q + ONE_A;
                            decim_cnt_d = '0;
                            if (fill_q != HALF_A)
                                fill_d = fill_q + ONE_A;
                        end else begin
                            decim_cnt_d = decim_cnt_q + 4'd1;
                        end
`else
                        if (trig_hit) begin
                            mem_we      = 1'b1;
                            mem_waddr   = '0;
                            wr_cnt_d    = ONE_C;
                            decim_cnt_d = '0;
                            state_d     = S_CAPTURE;
                        end
`endif
                    end
                end
                S_CAPTURE: begin
                    if (accept) begin
                        if (decim_hit) begin
                            mem_we      = 1'b1;
`ifdef TEST_CAPTURE_PRETRIG_EN
                            mem_waddr   = wr_ptr_q;
                            wr_ptr_d    = wr_ptr_q + ONE_A;
`else
                            mem_waddr   = wr_cnt_q[ADDR_W-1:0];
`endif
                            wr_cnt_d    = wr_cnt_q + ONE_C;
                            decim_cnt_d = '0;
                            if ((wr_cnt_q + ONE_C) == DEPTH_C)
                                state_d = S_DONE;
                        end else begin
                            decim_cnt_d = decim_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef TEST_CAPTURE_PRETRIG_EN
    assign mem_raddr = rd_base_q + rd_ptr_q;
`else
    assign mem_raddr = rd_ptr_q;
`endif

    assign rd_end_d = (state_d == S_DONE) && ({1'b0, rd_ptr_d} == (wr_cnt_d - ONE_C));

    always_comb begin
        status_d    = '0;
        status_d[0] = (state_d == S_ARMED);
        status_d[1] = (state_d == S_CAPTURE);
        status_d[2] = (state_d == S_DONE);
        status_d[3] = rd_end_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            decim_cnt_q <= '0;
            prev_q      <= '0;
            arm_dly_q   <= 1'b0;
            status_q    <= '0;
`ifdef TEST_CAPTURE_PRETRIG_EN
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            rd_base_q   <= '0;
`endif
        end else begin
            arm_dly_q <= cap_control_i[0];
            // With run low every counter holds, so capture resumes seamlessly.
            if (run_i || !test_dout_valid_i) begin
                state_q     <= state_d;
                wr_cnt_q    <= wr_cnt_d;
                rd_ptr_q    <= rd_ptr_d;
                decim_cnt_q <= decim_cnt_d;
                prev_q      <= prev_d;
                status_q    <= status_d;
`ifdef TEST_CAPTURE_PRETRIG_EN
                wr_ptr_q    <= wr_ptr_d;
                fill_q      <= fill_d;
                rd_base_q   <= rd_base_d;
`endif
            end else begin
                state_q     <= state_d;
                wr_cnt_q    <= wr_cnt_d;
                rd_ptr_q    <= rd_ptr_d;
                decim_cnt_q <= decim_cnt_d;
                prev_q      <= prev_d;
                status_q    <= status_d;
`ifdef TEST_CAPTURE_PRETRIG_EN
                wr_ptr_q    <= wr_ptr_d;
                fill_q      <= fill_d;
                rd_base_q   <= rd_base_d;
`endif
            end
        end
    end

    // Simple dual-port RAM: write port used only in ARMED/CAPTURE, read port in DONE.
    always_ff @(posedge clk_i) begin
        if (mem_we)
            mem[mem_waddr] <= test_data_out_i;
        rd_word_q <= mem[mem_raddr];
    end

    assign rd_lsb_data_o = (state_q == S_DONE) ? rd_word_q[7:0]  : 8'h00;
    assign rd_msb_data_o = (state_q == S_DONE) ? rd_word_q[15:8] : 8'h00;
    assign cap_status_o  = status_q;

endmodule

// File: tb/tb_test_capture_buffer.sv
// Directed bench for test_capture_buffer at ADDR_W=4 (16-sample depth).
module tb_test_capture_buffer;
    localparam int ADDR_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        valid;
    logic [15:0] din;
    logic [7:0]  ctrl;
    logic [7:0]  th_lsb;
    logic [7:0]  th_msb;
    logic        rd_en;
    logic [7:0]  rd_lsb;
    logic [7:0]  rd_msb;
    logic [7:0]  status;

    int tests_run    = 0;
    int tests_failed = 0;

    test_capture_buffer #(.ADDR_W(ADDR_W)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .run_i             (run),
        .test_dout_valid_i (valid),
        .test_data_out_i   (din),
        .cap_control_i     (ctrl),
        .cap_thresh_lsb_i  (th_lsb),
        .cap_thresh_msb_i  (th_msb),
        .rd_en_i           (rd_en),
        .rd_lsb_data_o     (rd_lsb),
        .rd_msb_data_o     (rd_msb),
        .cap_status_o      (status)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] s, input int gap);
        din   = s;
        valid = 1'b1;
        step(1);
        valid = 1'b0;
        if (gap > 1)
            step(gap - 1);
    endtask

    task automatic advance();
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        step(1);
    endtask

    task automatic arm(input logic [7:0] mode_bits);
        ctrl = mode_bits | 8'h01;
        step(1);
        ctrl = mode_bits;
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; valid = 1'b0; din = '0; ctrl = '0;
        th_lsb = '0; th_msb = '0; rd_en = 1'b0;
        step(2);
        check("reset_status", status, 8'h00);
        check("reset_lsb", rd_lsb, 8'h00);
        check("reset_msb", rd_msb, 8'h00);
        reset = 1'b0;
        step(1);

        // Immediate mode, every sample stored, strobe every 8 clk
        arm(8'h00);
        check("imm_armed", status, 8'h01);
        for (int i = 0; i < 15; i++) strobe(16'(i), 8);
        check("imm_capturing", status, 8'h02);
        strobe(16'h000F, 8);
        check("imm_done", status, 8'h04);
        for (int i = 16; i < 32; i++) strobe(16'(i), 8);
        check("imm_done_hold", status, 8'h04);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("imm_rd_lsb[%0d]", i), rd_lsb, 32'(i));
            check($sformatf("imm_rd_msb[%0d]", i), rd_msb, 32'h0);
            check($sformatf("imm_rd_status[%0d]", i), status, (i == 15) ? 32'h0C : 32'h04);
            if (i < 15) advance();
        end
        advance();
        check("imm_rd_sat_lsb", rd_lsb, 32'h0F);
        check("imm_rd_sat_status", status, 32'h0C);
        ctrl = 8'h08;
        step(1);
        ctrl = 8'h00;
        step(1);
        check("imm_rd_rst_lsb", rd_lsb, 32'h00);
        check("imm_rd_rst_status", status, 32'h04);

        // Threshold mode, rising crossing of 0x0100
        th_lsb = 8'h00; th_msb = 8'h01;
        arm(8'h02);
        check("thr_armed", status, 8'h01);
        strobe(16'h0080, 2);
        check("thr_below", status, 8'h01);
        strobe(16'h0120, 2);
        check("thr_trig", status, 8'h02);
        strobe(16'h0200, 2);
        strobe(16'h0050, 2);
        strobe(16'h0110, 2);
        for (int k = 0; k < 12; k++) strobe(16'h1000 + 16'(k), 2);
        check("thr_done", status, 8'h04);
        check("thr_a0_lsb", rd_lsb, 8'h20);
        check("thr_a0_msb", rd_msb, 8'h01);
        advance();
        check("thr_a1_lsb", rd_lsb, 8'h00);
        check("thr_a1_msb", rd_msb, 8'h02);
        advance();
        check("thr_a2_lsb", rd_lsb, 8'h50);
        check("thr_a3_msb", rd_msb, 8'h00);
        ctrl = 8'h00;
        step(1);

        // Decimation 3: keep 1 in 4
        arm(8'h30);
        for (int i = 0; i < 60; i++) strobe(16'(i), 2);
        check("dec_capturing", status, 8'h02);
        strobe(16'd60, 2);
        check("dec_done", status, 8'h04);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("dec_rd[%0d]", i), rd_lsb, 32'(4 * i));
            if (i < 15) advance();
        end
        ctrl = 8'h00;
        step(1);

        // run dropped for 20 clk mid-capture with strobes still arriving
        arm(8'h00);
        for (int i = 0; i < 5; i++) strobe(16'(i), 2);
        check("run_wr_cnt_pre", 32'(dut.wr_cnt_q), 32'd5);
        run = 1'b0;
        for (int k = 0; k < 10; k++) strobe(16'h0100 + 16'(k), 2);
        check("run_wr_cnt_held", 32'(dut.wr_cnt_q), 32'd5);
        check("run_status_held", status, 8'h02);
        run = 1'b1;
        for (int i = 5; i < 16; i++) strobe(16'(i), 2);
        check("run_done", status, 8'h04);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("run_rd[%0d]", i), {rd_msb, rd_lsb}, 32'(i));
            if (i < 15) advance();
        end

        // Abort at wr_cnt=5, then arm and abort together
        arm(8'h00);
        for (int i = 0; i < 5; i++) strobe(16'h0040 + 16'(i), 2);
        check("abt_wr_cnt", 32'(dut.wr_cnt_q), 32'd5);
        check("abt_capturing", status, 8'h02);
        ctrl = 8'h04;
        step(1);
        check("abt_status", status, 8'h00);
        check("abt_wr_cnt_clr", 32'(dut.wr_cnt_q), 32'd0);
        ctrl = 8'h00;
        step(1);
        ctrl = 8'h05;
        step(1);
        check("abt_arm_same_clk", status, 8'h00);
        ctrl = 8'h00;
        step(1);
        check("abt_idle_stays", status, 8'h00);

        // Asynchronous reset mid-capture, checked before the next clock edge
        arm(8'h00);
        strobe(16'h00AA, 2);
        strobe(16'h00BB, 2);
        strobe(16'h00CC, 2);
        check("rst_capturing", status, 8'h02);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_status", status, 8'h00);
        check("rst_async_lsb", rd_lsb, 8'h00);
        check("rst_async_msb", rd_msb, 8'h00);
        check("rst_async_rd_ptr", 32'(dut.rd_ptr_q), 32'd0);
        check("rst_async_wr_cnt", 32'(dut.wr_cnt_q), 32'd0);
        step(2);
        reset = 1'b0;
        step(1);
        check("rst_released_idle", status, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
